hazard_stall_ctrl: RTL and testbench

Pipeline control unit for the five-stage core that sequences the IF/ID, ID/EX and EX/MEM pipeline registers. Each cycle it decides whether every stage advances, holds, or is cleared to a bubble. Triggers are load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. It is the single source of the write-enable and flush inputs of the pipeline registers and the PC.

---
 rtl/hazard_stall_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_ctrl_hazard_detect.sv | 19 +
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared core definitions for the pipeline stall/flush controller.
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    TIMEOUT  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline advance/hold/flush controller for the five-stage core.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_we,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_we,
  output logic                  mem_timeout,
  output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      loaduse_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  ctrl_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              mem_release;
  logic              run_decode;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_stall   = dmem_req && !dmem_ready;
  assign mem_release = dmem_req && dmem_ready;
  assign mem_timeout = (state == TIMEOUT);
  assign ctrl_state  = state;

  // The release cycle of MEM_WAIT decodes like RUN, since EX/ID were held during the wait.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b0;
    run_decode   = 1'b0;
    case (state)
      INIT: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      RUN:      run_decode = !mem_stall;
      MEM_WAIT: run_decode = mem_release;
      default:  run_decode = 1'b0;
    endcase
    if (run_decode) begin
      if (ex_branch_taken) begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_we    = 1'b1;
      end else if (load_use) begin
        id_ex_we     = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_we    = 1'b1;
      end else begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      wait_cnt <= '0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
          if (mem_release) state <= RUN;
          else if (wait_cnt >= WAIT_LAST) state <= TIMEOUT;
        end
        default: state <= TIMEOUT;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;
  logic loaduse_evt;

  // A bubble without an IF/ID flush can only come from the load-use case.
  assign stall_evt   = !pc_we && ((state == RUN) || (state == MEM_WAIT));
  assign flush_evt   = pc_we && if_id_flush;
  assign loaduse_evt = id_ex_bubble && !if_id_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      loaduse_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1))     stall_cnt   <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1))     flush_cnt   <= flush_cnt + CNT_W'(1);
      if (loaduse_evt && (loaduse_cnt != '1)) loaduse_cnt <= loaduse_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MAX_WAIT=4); counter test needs HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 16;

  // Packed as {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble}
  localparam logic [5:0] P_INIT   = 6'b0000_11;
  localparam logic [5:0] P_RUN    = 6'b1111_00;
  localparam logic [5:0] P_FREEZE = 6'b0000_00;
  localparam logic [5:0] M_LU     = 6'b1101_11;
  localparam logic [5:0] P_LU     = 6'b0001_01;
  localparam logic [5:0] M_BR     = 6'b1001_11;
  localparam logic [5:0] P_BR     = 6'b1001_11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken;
  logic       dmem_req, dmem_ready;
  logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we;
  logic       mem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, loaduse_cnt;
`endif

  int errors = 0;
  int checks = 0;

  hazard_stall_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_we        (id_ex_we),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_we       (ex_mem_we),
    .mem_timeout     (mem_timeout),
    .ctrl_state      (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .loaduse_cnt     (loaduse_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ctl();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble};
  endfunction

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ctl() !== P_INIT) begin errors++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl(), P_INIT); end
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", ctrl_state); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", mem_timeout); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ctl() !== P_INIT || ctrl_state !== 2'd0) begin errors++; $display("[TB] FAIL init_cycle: got ctl=%b state=%0d expected ctl=%b state=0", ctl(), ctrl_state, P_INIT); end
    next_cycle();
    @(negedge clk);
    checks++; if (ctl() !== P_RUN || ctrl_state !== 2'd1) begin errors++; $display("[TB] FAIL first_run: got ctl=%b state=%0d expected ctl=%b state=1", ctl(), ctrl_state, P_RUN); end
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    @(negedge clk);
    checks++; if ((ctl() & M_LU) !== P_LU) begin errors++; $display("[TB] FAIL lu_rs2: got %b expected %b (mask %b)", ctl(), P_LU, M_LU); end
    next_cycle();
    ex_memread = 1'b0; ex_rd = 5'd0;
    @(negedge clk);
    checks++; if (ctl() !== P_RUN) begin errors++; $display("[TB] FAIL lu_after: got %b expected %b", ctl(), P_RUN); end
    next_cycle();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_rs2 = 5'd0;
    @(negedge clk);
    checks++; if ((ctl() & M_LU) !== P_LU) begin errors++; $display("[TB] FAIL lu_rs1: got %b expected %b (mask %b)", ctl(), P_LU, M_LU); end
    next_cycle();
    id_uses_rs1 = 1'b0;
    @(negedge clk);
    checks++; if (ctl() !== P_RUN) begin errors++; $display("[TB] FAIL lu_unused_src: got %b expected %b", ctl(), P_RUN); end
    next_cycle();
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++; if (ctl() !== P_RUN) begin errors++; $display("[TB] FAIL lu_x0: got %b expected %b", ctl(), P_RUN); end
    next_cycle();
    ex_memread = 1'b0; ex_rd = 5'd5; id_rs2 = 5'd5;
    @(negedge clk);
    checks++; if (ctl() !== P_RUN) begin errors++; $display("[TB] FAIL lu_not_load: got %b expected %b", ctl(), P_RUN); end
    next_cycle();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    @(negedge clk);
    checks++; if ((ctl() & M_BR) !== P_BR) begin errors++; $display("[TB] FAIL br_over_lu: got %b expected %b (mask %b)", ctl(), P_BR, M_BR); end
    next_cycle();
    clear_inputs();
    ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++; if ((ctl() & M_BR) !== P_BR) begin errors++; $display("[TB] FAIL br_alone: got %b expected %b (mask %b)", ctl(), P_BR, M_BR); end
    next_cycle();
  endtask

  task automatic test_mem_stall();
    clear_inputs();
    ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (ctl() !== P_FREEZE || ctrl_state !== 2'd1) begin errors++; $display("[TB] FAIL mem_first: got ctl=%b state=%0d expected ctl=%b state=1", ctl(), ctrl_state, P_FREEZE); end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (ctl() !== P_FREEZE || ctrl_state !== 2'd2) begin errors++; $display("[TB] FAIL mem_wait%0d: got ctl=%b state=%0d expected ctl=%b state=2", i, ctl(), ctrl_state, P_FREEZE); end
    end
    next_cycle();
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if ((ctl() & M_BR) !== P_BR || ctrl_state !== 2'd2) begin errors++; $display("[TB] FAIL mem_release_br: got ctl=%b state=%0d expected ctl=%b state=2", ctl(), ctrl_state, P_BR); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (ctl() !== P_RUN || ctrl_state !== 2'd1) begin errors++; $display("[TB] FAIL mem_back_run: got ctl=%b state=%0d expected ctl=%b state=1", ctl(), ctrl_state, P_RUN); end
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (ctl() !== P_RUN) begin errors++; $display("[TB] FAIL mem_same_cycle: got %b expected %b", ctl(), P_RUN); end
    next_cycle();
    dmem_req = 1'b0; dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (ctl() !== P_RUN || ctrl_state !== 2'd1) begin errors++; $display("[TB] FAIL ready_no_req: got ctl=%b state=%0d expected ctl=%b state=1", ctl(), ctrl_state, P_RUN); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    clear_inputs();
    dmem_req = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_state !== 2'd1) begin errors++; $display("[TB] FAIL to_run: got %0d expected 1", ctrl_state); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (ctrl_state !== 2'd2 || mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_wait%0d: got state=%0d timeout=%b expected state=2 timeout=0", i, ctrl_state, mem_timeout); end
    end
    next_cycle();
    @(negedge clk);
    checks++; if (ctrl_state !== 2'd3 || mem_timeout !== 1'b1 || ctl() !== P_FREEZE) begin errors++; $display("[TB] FAIL to_enter: got state=%0d timeout=%b ctl=%b expected state=3 timeout=1 ctl=%b", ctrl_state, mem_timeout, ctl(), P_FREEZE); end
    next_cycle();
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (ctrl_state !== 2'd3 || mem_timeout !== 1'b1 || ctl() !== P_FREEZE) begin errors++; $display("[TB] FAIL to_sticky: got state=%0d timeout=%b ctl=%b expected state=3 timeout=1 ctl=%b", ctrl_state, mem_timeout, ctl(), P_FREEZE); end
    next_cycle();
    #2 rst = 1'b0;
    #1;
    checks++; if (ctrl_state !== 2'd0 || mem_timeout !== 1'b0 || ctl() !== P_INIT) begin errors++; $display("[TB] FAIL to_async_reset: got state=%0d timeout=%b ctl=%b expected state=0 timeout=0 ctl=%b", ctrl_state, mem_timeout, ctl(), P_INIT); end
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0 || loaduse_cnt !== '0) begin errors++; $display("[TB] FAIL perf_reset: got stall=%0d flush=%0d lu=%0d expected 0 0 0", stall_cnt, flush_cnt, loaduse_cnt); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      next_cycle();
      clear_inputs();
      next_cycle();
    end
    ex_branch_taken = 1'b1;
    next_cycle();
    clear_inputs();
    dmem_req = 1'b1;
    repeat (3) next_cycle();
    dmem_ready = 1'b1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (loaduse_cnt !== CNT_W'(2)) begin errors++; $display("[TB] FAIL perf_loaduse: got %0d expected 2", loaduse_cnt); end
    checks++; if (flush_cnt !== CNT_W'(1)) begin errors++; $display("[TB] FAIL perf_flush: got %0d expected 1", flush_cnt); end
    checks++; if (stall_cnt !== CNT_W'(5)) begin errors++; $display("[TB] FAIL perf_stall: got %0d expected 5", stall_cnt); end
    next_cycle();
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_stall();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
